// File: rtl/exhaustive_sweeper_pkg.sv
// sweep_pkg: shared state encoding and helpers for the exhaustive sweeper.
package sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t;
  function automatic int last_vec(input int n);
    return (1 << n) - 1;
  endfunction
endpackage

// File: rtl/exhaustive_sweeper_hold_timer.sv
// hold_timer: counts cycles a vector is held and flags the last hold cycle.
module hold_timer #(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(HOLD + 1);
  logic [W-1:0] t;
  always_ff @(posedge clk or posedge rst)
    if (rst) t <= '0;
    else if (clear) t <= '0;
    else if (enable) t <= t + W'(1);
  assign expire = t == W'(HOLD - 1);
endmodule

// File: rtl/exhaustive_sweeper.sv
// exhaustive_sweeper: drives every input vector in order and counts DUT/golden mismatches.
module exhaustive_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int HOLD  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] dut_resp,
  input  logic [N_OUT-1:0] exp_resp,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [N_OUT-1:0] first_err_resp
);
  localparam logic [N_IN-1:0] LAST = N_IN'(last_vec(N_IN));
  sweep_state_t state, state_n;
  logic expire, go, last, mismatch;
  hold_timer #(.HOLD(HOLD)) u_timer (
    .clk(clk), .rst(rst), .clear(state != DRIVE), .enable(state == DRIVE), .expire(expire)
  );
  assign sample   = state == SAMPLE;
  assign go       = start && (state == IDLE || state == DONE);
  assign last     = vec == LAST;
  assign mismatch = dut_resp != exp_resp;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = go ? DRIVE : state;
      DRIVE:      state_n = expire ? SAMPLE : DRIVE;
      SAMPLE:     state_n = last ? DONE : DRIVE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_resp  <= '0;
    end else begin
      state <= state_n;
      busy  <= state_n == DRIVE || state_n == SAMPLE;
      done  <= state_n == DONE;
      if (go) begin
        vec             <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
        first_err_resp  <= '0;
      end else if (sample) begin
        if (mismatch) begin
          err_count <= err_count + (N_IN + 1)'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= vec;
            first_err_resp  <= dut_resp;
          end
        end
        if (!last) vec <= vec + N_IN'(1);
      end
    end
endmodule
